pb_debouncer_multi: RTL and testbench
=====================================

// Module: pb_debouncer_multi
// PURPOSE
//   Debounces NUM_CH independent push-buttons. Each channel has its own 2-FF synchroniser and
//   debounce FSM. Both the press and the release are debounced. Each channel produces press and
//   release pulses, a long-press pulse and an optional auto-repeat pulse.
//   Sits between the board buttons and the user-logic FSMs, and replaces per-button instances.
// PARAMETERS
//   NUM_CH     4      number of button channels
//   DEB_CYC    16     consecutive stable cycles required to accept a press or a release (>=1)
//   LONG_CYC   1000   hold cycles, counted from pressed_pulse, before long_press_pulse (>=1)
//   REP_CYC    250    auto-repeat period after long press, in cycles (>=1)
//   REPEAT_EN  1      1: generate repeat_pulse; 0: repeat_pulse tied low
//   ACTIVE_LOW 0      1: raw button reads 0 when pressed (inverted at the synchroniser input)
// PORTS
//   clock             in   1       system clock; all logic on its rising edge
//   reset             in   1       synchronous, active-high reset
//   PB                in   NUM_CH  raw asynchronous button inputs, one bit per channel
//   PB_pressed_state  out  NUM_CH  debounced level: 1 while the channel is accepted as pressed
//   PB_pressed_pulse  out  NUM_CH  1-cycle pulse on an accepted press
//   PB_released_pulse out  NUM_CH  1-cycle pulse on an accepted release
//   long_press_pulse  out  NUM_CH  1-cycle pulse, LONG_CYC cycles after PB_pressed_pulse
//   repeat_pulse      out  NUM_CH  1-cycle pulse every REP_CYC cycles after long_press_pulse
// BEHAVIOUR
//   - Channels are fully independent. Simultaneous events on different channels resolve in the
//     same cycle with no priority between channels.
//   - Sync: s = {s[0], PB[i]^ACTIVE_LOW}. The FSM uses s[1] only.
//   - On reset, s resets to 2'b00 (the inactive level after polarity inversion).
//   - Debounce counter width is $clog2(DEB_CYC+1).
//   - Hold and repeat counter widths are $clog2(max(LONG_CYC,REP_CYC)+1).
//   - FSM states (per channel):
//       IDLE   : s1=1 -> PCNT (cnt=0). Otherwise stay.
//       PCNT   : s1=0 -> IDLE. cnt==DEB_CYC-1 -> PRESS. Otherwise cnt++.
//       PRESS  : 1 cycle -> HOLD. Hold counter cleared.
//       HOLD   : s1=0 -> RCNT (cnt=0). Otherwise stay.
//       RCNT   : s1=1 -> HOLD (glitch rejected, no pulses). cnt==DEB_CYC-1 -> REL. Otherwise cnt++.
//       REL    : 1 cycle -> IDLE.
//   - The debounce counter is held at 0 in every state other than PCNT and RCNT.
//   - Output decode:
//       PB_pressed_state  = state in {PRESS, HOLD, RCNT}
//       PB_pressed_pulse  = (state == PRESS)
//       PB_released_pulse = (state == REL)
//     These outputs are decoded from the state register only, so they are Moore outputs.
//   - Latency: raw PB held stable from clock edge k -> PB_pressed_pulse is high in the cycle
//     after edge k+DEB_CYC+2. The release path has the same latency.
//   - Hold counter:
//       runs in HOLD and RCNT, starting at the PRESS cycle;
//       on reaching LONG_CYC it fires long_press_pulse once (registered, 1 cycle) and saturates;
//       it does not restart until the next PRESS.
//   - Repeat (REPEAT_EN=1):
//       the repeat counter starts on the long_press_pulse cycle;
//       repeat_pulse fires every REP_CYC cycles while state is in {HOLD, RCNT};
//       the counter is cleared in every other state.
//   - A release accepted before LONG_CYC: no long_press_pulse and no repeat_pulse for that press.
//   - A long or repeat pulse never coincides with PB_released_pulse. The REL state suppresses them.
//   - Reset:
//       all outputs 0, all FSMs IDLE, all counters 0;
//       reset asserted mid-press aborts the press with no PB_released_pulse;
//       after reset deasserts, a still-held button needs a full DEB_CYC qualification again.
//   - Bounce shorter than DEB_CYC cycles at either edge produces no pulse and no state change.
// TESTING
//   1) NUM_CH=4, DEB_CYC=4. Ch0 held high 20 cycles -> one PB_pressed_pulse exactly 7 cycles
//      after the first sampling edge. Ch1-3 outputs stay 0.
//   2) Ch0 toggles with high periods of 3 cycles -> no pulses. Then stable high -> exactly one
//      PB_pressed_pulse.
//   3) Release bounce: after a press, PB low 2 cycles then high -> no PB_released_pulse and
//      PB_pressed_state stays 1. Then low 10 cycles -> one PB_released_pulse 7 cycles after the
//      low edge.
//   4) LONG_CYC=20, REP_CYC=5, REPEAT_EN=1. Hold 60 cycles ->
//      long_press_pulse 20 cycles after PB_pressed_pulse;
//      repeat_pulse at +25, +30, ...;
//      none after PB_released_pulse.
//   5) ACTIVE_LOW=1. Raw PB=0 on ch2 and ch3 in the same cycle -> both PB_pressed_pulse in the
//      same cycle. With PB=all-ones at reset -> no pulses.
//   6) Assert reset during HOLD on ch0 -> all outputs 0 on the next cycle with no
//      PB_released_pulse. Button still held after reset -> new PB_pressed_pulse after DEB_CYC+3.

Source files
------------

// File: rtl/pb_debouncer_multi_if.sv
// Button-side bundle for the multi-channel debouncer. Raw inputs flow to the slave (debouncer),
// and the debounced levels and event pulses flow back to the master (user logic / board side).
interface pb_debouncer_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] PB;
  logic [NUM_CH-1:0] PB_pressed_state;
  logic [NUM_CH-1:0] PB_pressed_pulse;
  logic [NUM_CH-1:0] PB_released_pulse;
  logic [NUM_CH-1:0] long_press_pulse;
  logic [NUM_CH-1:0] repeat_pulse;

  modport master (
    output PB,
    input  PB_pressed_state, PB_pressed_pulse, PB_released_pulse,
           long_press_pulse, repeat_pulse
  );

  modport slave (
    input  PB,
    output PB_pressed_state, PB_pressed_pulse, PB_released_pulse,
           long_press_pulse, repeat_pulse
  );
endinterface

// File: rtl/pb_debouncer_multi.sv
// NUM_CH independent push-button debouncers: 2-FF synchroniser, press/release qualification FSM,
// long-press detection and optional auto-repeat per channel.
module pb_debouncer_multi #(
  parameter int NUM_CH     = 4,
  parameter int DEB_CYC    = 16,
  parameter int LONG_CYC   = 1000,
  parameter int REP_CYC    = 250,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  pb_debouncer_multi_if.slave  bus
);

  localparam int MAX_CYC = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int HLD_W   = $clog2(MAX_CYC + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HLD_W-1:0] LONG_LAST = HLD_W'(LONG_CYC - 1);
  localparam logic [HLD_W-1:0] LONG_SAT  = HLD_W'(LONG_CYC);
  localparam logic [HLD_W-1:0] REP_LAST  = HLD_W'(REP_CYC - 1);
  localparam logic             POL       = (ACTIVE_LOW != 0);
  localparam logic             REP_ON    = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    IDLE, PCNT, PRESS, HOLD, RCNT, REL
  } state_t;

  logic [NUM_CH-1:0] state_v, press_v, rel_v, long_v, rep_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [1:0]       sync_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic [HLD_W-1:0] rep_q, rep_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             s1, counting, keep;

    assign s1       = sync_q[1];
    assign counting = (state_q == PRESS) || (state_q == HOLD) || (state_q == RCNT);
    // Long/repeat pulses only survive into cycles that stay pressed, which keeps them off REL.
    assign keep     = (state_d == HOLD) || (state_d == RCNT);

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
        IDLE:    if (s1) state_d = PCNT;
        PCNT: begin
          if (!s1)                  state_d = IDLE;
          else if (cnt_q == DEB_LAST) state_d = PRESS;
          else                      cnt_d   = cnt_q + 1'b1;
        end
        PRESS:   state_d = HOLD;
        HOLD:    if (!s1) state_d = RCNT;
        RCNT: begin
          if (s1)                   state_d = HOLD;
          else if (cnt_q == DEB_LAST) state_d = REL;
          else                      cnt_d   = cnt_q + 1'b1;
        end
        REL:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      rep_d  = '0;
      rpt_d  = 1'b0;
      if (counting) begin
        hold_d = (hold_q == LONG_SAT) ? hold_q : hold_q + 1'b1;
        long_d = (hold_q == LONG_LAST) && keep;
        // Saturated hold counter marks "long press seen"; repeat period is measured from there.
        if (REP_ON && (hold_q == LONG_SAT)) begin
          if (rep_q == REP_LAST) rpt_d = keep;
          else                   rep_d = rep_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q  <= 2'b00;
        state_q <= IDLE;
        cnt_q   <= '0;
        hold_q  <= '0;
        rep_q   <= '0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], bus.PB[i] ^ POL};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
      end
    end

    assign state_v[i] = counting;
    assign press_v[i] = (state_q == PRESS);
    assign rel_v[i]   = (state_q == REL);
    assign long_v[i]  = long_q;
    assign rep_v[i]   = rpt_q;
  end

  assign bus.PB_pressed_state  = state_v;
  assign bus.PB_pressed_pulse  = press_v;
  assign bus.PB_released_pulse = rel_v;
  assign bus.long_press_pulse  = long_v;
  assign bus.repeat_pulse      = rep_v;

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed bench: active-high instance A (press, bounce, release, long/repeat, reset abort) and
// active-low instance B (simultaneous presses, idle-high inputs).
module tb_pb_debouncer_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] a_pb  = 4'h0;
  logic [3:0] b_pb  = 4'hF;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // ch0 event log for instance A
  int np, nr, nl, nrep, t_press, t_rel, t_long, t_rep_first, t_rep_last, overlap;
  int a_other = 0;
  // instance B per-channel press log
  int b_np[4];
  int b_tp[4];
  int b_any = 0;

  pb_debouncer_multi_if #(.NUM_CH(4)) ifa ();
  pb_debouncer_multi_if #(.NUM_CH(4)) ifb ();

  assign ifa.PB = a_pb;
  assign ifb.PB = b_pb;

  pb_debouncer_multi #(
    .NUM_CH(4), .DEB_CYC(4), .LONG_CYC(20), .REP_CYC(5), .REPEAT_EN(1), .ACTIVE_LOW(0)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  pb_debouncer_multi #(
    .NUM_CH(4), .DEB_CYC(4), .LONG_CYC(20), .REP_CYC(5), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    np = 0; nr = 0; nl = 0; nrep = 0; overlap = 0;
    t_press = -1; t_rel = -1; t_long = -1; t_rep_first = -1; t_rep_last = -1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (ifa.PB_pressed_pulse[0])  begin np++; t_press = cyc; end
    if (ifa.PB_released_pulse[0]) begin nr++; t_rel = cyc; end
    if (ifa.long_press_pulse[0])  begin nl++; t_long = cyc; end
    if (ifa.repeat_pulse[0]) begin
      if (nrep == 0) t_rep_first = cyc;
      nrep++;
      t_rep_last = cyc;
    end
    if (ifa.PB_released_pulse[0] && (ifa.long_press_pulse[0] || ifa.repeat_pulse[0])) overlap++;
    if ((ifa.PB_pressed_state[3:1] | ifa.PB_pressed_pulse[3:1] | ifa.PB_released_pulse[3:1] |
         ifa.long_press_pulse[3:1] | ifa.repeat_pulse[3:1]) != 3'b000) a_other++;
    for (int c = 0; c < 4; c++) begin
      if (ifb.PB_pressed_pulse[c]) begin b_np[c]++; b_tp[c] = cyc; end
    end
    if ((ifb.PB_pressed_state | ifb.PB_pressed_pulse | ifb.PB_released_pulse |
         ifb.long_press_pulse | ifb.repeat_pulse) != 4'h0) b_any++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int t0, t1, t2, t3, tb0, p;
    for (int c = 0; c < 4; c++) begin b_np[c] = 0; b_tp[c] = -1; end
    clr();

    // reset state
    run(3);
    chk("rst_a_state", int'(ifa.PB_pressed_state), 0);
    chk("rst_a_pulses", int'(ifa.PB_pressed_pulse | ifa.PB_released_pulse |
                             ifa.long_press_pulse | ifa.repeat_pulse), 0);
    chk("rst_b_state", int'(ifb.PB_pressed_state), 0);
    reset = 1'b0;
    run(2);

    // 1) clean press on ch0
    clr();
    t0 = cyc;
    a_pb[0] = 1'b1;
    run(20);
    chk("t1_press_count", np, 1);
    chk("t1_press_latency", t_press - t0, 7);
    chk("t1_state", int'(ifa.PB_pressed_state[0]), 1);
    chk("t1_other_ch_quiet", a_other, 0);

    // 3) release bounce rejected, then real release
    clr();
    a_pb[0] = 1'b0;
    run(2);
    a_pb[0] = 1'b1;
    run(8);
    chk("t3_bounce_no_rel", nr, 0);
    chk("t3_bounce_state", int'(ifa.PB_pressed_state[0]), 1);
    clr();
    t1 = cyc;
    a_pb[0] = 1'b0;
    run(10);
    chk("t3_rel_count", nr, 1);
    chk("t3_rel_latency", t_rel - t1, 7);
    chk("t3_state_after", int'(ifa.PB_pressed_state[0]), 0);

    // 2) press bounce with 3-cycle highs, then stable press released before LONG_CYC
    clr();
    for (int r = 0; r < 3; r++) begin
      a_pb[0] = 1'b1;
      run(3);
      a_pb[0] = 1'b0;
      run(3);
    end
    chk("t2_bounce_no_press", np, 0);
    chk("t2_bounce_state", int'(ifa.PB_pressed_state[0]), 0);
    a_pb[0] = 1'b1;
    run(15);
    chk("t2_press_count", np, 1);
    a_pb[0] = 1'b0;
    run(10);
    chk("t2_rel_count", nr, 1);
    chk("t2_short_no_long", nl, 0);
    chk("t2_short_no_rep", nrep, 0);

    // 4) long press and auto-repeat, release suppresses the pulse landing on REL
    clr();
    t2 = cyc;
    a_pb[0] = 1'b1;
    run(60);
    a_pb[0] = 1'b0;
    run(15);
    p = t2 + 7;
    chk("t4_press_time", t_press, p);
    chk("t4_long_count", nl, 1);
    chk("t4_long_delay", t_long - t_press, 20);
    chk("t4_rep_first", t_rep_first - t_press, 25);
    chk("t4_rep_last", t_rep_last - t2, 62);
    chk("t4_rep_count", nrep, 7);
    chk("t4_rel_time", t_rel - t2, 67);
    chk("t4_no_overlap", overlap, 0);
    chk("t4_other_ch_quiet", a_other, 0);

    // 5) active-low instance: idle-high inputs silent, ch2/ch3 pressed together
    chk("t5_b_idle_quiet", b_any, 0);
    tb0 = cyc;
    b_pb = 4'b0011;
    run(10);
    chk("t5_b_ch2_count", b_np[2], 1);
    chk("t5_b_ch3_count", b_np[3], 1);
    chk("t5_b_ch2_time", b_tp[2] - tb0, 7);
    chk("t5_b_ch3_time", b_tp[3] - tb0, 7);
    chk("t5_b_ch01_quiet", b_np[0] + b_np[1], 0);
    chk("t5_b_state", int'(ifb.PB_pressed_state), 12);

    // 6) reset during HOLD aborts silently; held button requalifies
    clr();
    a_pb[0] = 1'b1;
    run(12);
    chk("t6_hold_state", int'(ifa.PB_pressed_state[0]), 1);
    reset = 1'b1;
    run(1);
    chk("t6_rst_state", int'(ifa.PB_pressed_state), 0);
    chk("t6_rst_pulses", int'(ifa.PB_pressed_pulse | ifa.PB_released_pulse |
                              ifa.long_press_pulse | ifa.repeat_pulse), 0);
    run(1);
    np = 0;
    reset = 1'b0;
    t3 = cyc;
    run(10);
    chk("t6_no_rel", nr, 0);
    chk("t6_repress_count", np, 1);
    chk("t6_repress_latency", t_press - t3, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
